murmur3_stream_ctrl: RTL and testbench
======================================

// Module: murmur3_stream_ctrl
// PURPOSE
//  Sequences the MurmurHash3 x86_32 datapath over a variable-length byte message.
//  Accepts seed+length, then streams 32-bit little-endian chunks over valid/ready.
//  Applies the 4-byte block mix per body word, the tail mix for 1-3 leftover bytes and the fmix32 finaliser.
//  Presents the 32-bit hash on a valid/ready output. Sits between a message source and the hash consumer.
// PARAMETERS
//  LEN_W  16  width of byte-length input; max message = 2**LEN_W-1 bytes
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      pulse: latch seed_i/len_i, begin job (honoured in IDLE only)
//  seed_i       in   32     hash seed
//  len_i        in   LEN_W  message length in bytes
//  chunk_valid  in   1      chunk_data valid
//  chunk_data   in   32     message word, byte0 in [7:0] (little-endian)
//  chunk_ready  out  1      controller accepts chunk this cycle
//  hash_valid   out  1      hash_out valid, held until hash_ready
//  hash_out     out  32     final hash
//  hash_ready   in   1      consumer accepts hash
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; h, len, word counter = 0; chunk_ready=0, hash_valid=0, hash_out=0, busy=0.
//  FSM: IDLE -> BODY -> TAIL -> FIN1 -> FIN2 -> FIN3 -> DONE -> IDLE.
//  IDLE: on start: h<=seed_i, len<=len_i, nwords<=len_i>>2. Next: BODY if nwords!=0,
//    else TAIL if len_i[1:0]!=0, else FIN1. start in any other state is ignored (no queueing).
//  BODY: chunk_ready=1. Each chunk_valid&&chunk_ready: k=chunk*0xcc9e2d51; k=rol15(k);
//    k*=0x1b873593; h=rol13(h^k)*5+0xe6546b64; nwords-=1. After last word -> TAIL if len[1:0]!=0 else FIN1.
//    One word per cycle max; no accept while chunk_valid=0 (stall holds all state).
//  TAIL: chunk_ready=1; one word accepted; bytes at index >= len[1:0] masked to 0 before mixing.
//    k=masked*0xcc9e2d51; rol15; *0x1b873593; h^=k (no rol13, no *5+n). -> FIN1.
//  FIN1: h^=len (zero-extended to 32); h^=h>>16; h*=0x85ebca6b.  FIN2: h^=h>>13; h*=0xc2b2ae35.
//  FIN3: h^=h>>16; hash_out<=h; hash_valid<=1. -> DONE.
//  DONE: hash_valid=1, hash_out stable; on hash_ready -> IDLE, hash_valid<=0 next cycle.
//    start in the DONE handshake cycle is ignored; next job starts from IDLE.
//  Latency after last chunk accepted: hash_valid rises 3 cycles later (FIN1..FIN3). len=0: start->hash_valid 3 cycles.
//  All arithmetic mod 2**32 (keep low 32 bits of every product). len_i upper bits beyond 32 n/a (LEN_W<=32).
//  chunk_ready=0 in IDLE/FIN*/DONE; chunk_valid there is ignored, no data consumed.
//  Async reset mid-job: immediate return to reset state; partial hash discarded; no hash_valid.
// TESTING
//  len=0 seed=0x00000000 -> hash 0x00000000, no chunk_ready asserted, valid 3 cycles after start.
//  len=0 seed=0x00000001 -> 0x514E28B7; seed=0xFFFFFFFF -> 0x81F16F39.
//  "test" len=4 seed=0, chunk 0x74736574 -> 0xBA6BD213; chunk_valid delayed 5 cycles -> same result.
//  "Hello, world!" len=13 seed=1234 (3 body words + tail with garbage upper bytes 0xAAAAAA) -> 0xFAF6CDB3.
//  hash_ready held low 10 cycles -> hash_valid/hash_out stable; start pulses while busy ignored, result unchanged.
//  rst_n low mid-BODY then new job "test" seed=0 -> outputs reset immediately, then 0xBA6BD213.

Source files
------------

// File: rtl/murmur3_stream_ctrl.sv
// Streams a byte message through MurmurHash3 x86_32: body mixes, masked tail mix, fmix32
// finaliser, then holds the hash on a valid/ready output until the consumer takes it.
module murmur3_stream_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             chunk_valid,
  input  logic [31:0]      chunk_data,
  output logic             chunk_ready,
  output logic             hash_valid,
  output logic [31:0]      hash_out,
  input  logic             hash_ready,
  output logic             busy
);

  localparam logic [31:0] C1 = 32'hcc9e2d51;
  localparam logic [31:0] C2 = 32'h1b873593;

  typedef enum logic [2:0] {StIdle, StBody, StTail, StFin1, StFin2, StFin3, StDone} state_e;

  state_e           state_q;
  logic [31:0]      h_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] nwords_q;
  logic             chunk_ready_q;
  logic             hash_valid_q;
  logic [31:0]      hash_out_q;
  logic             busy_q;

  function automatic logic [31:0] mix_k(input logic [31:0] w);
    logic [31:0] t;
    t = w * C1;
    t = {t[16:0], t[31:17]};
    return t * C2;
  endfunction

  logic [31:0] tail_mask;
  logic [31:0] k_body, k_tail, h_mix, h_body;
  logic [31:0] f1_a, f1_b, f2_a, h_fin1, h_fin2, h_fin3;

  // Only bytes below len[1:0] belong to the message; the rest of the tail word is garbage.
  always_comb begin
    tail_mask = 32'hffffffff;
    unique case (len_q[1:0])
      2'd1:    tail_mask = 32'h000000ff;
      2'd2:    tail_mask = 32'h0000ffff;
      2'd3:    tail_mask = 32'h00ffffff;
      default: tail_mask = 32'hffffffff;
    endcase
  end

  assign k_body = mix_k(chunk_data);
  assign k_tail = mix_k(chunk_data & tail_mask);
  assign h_mix  = h_q ^ k_body;
  assign h_body = {h_mix[18:0], h_mix[31:19]} * 32'd5 + 32'he6546b64;

  assign f1_a   = h_q ^ 32'(len_q);
  assign f1_b   = f1_a ^ (f1_a >> 16);
  assign h_fin1 = f1_b * 32'h85ebca6b;
  assign f2_a   = h_q ^ (h_q >> 13);
  assign h_fin2 = f2_a * 32'hc2b2ae35;
  assign h_fin3 = h_q ^ (h_q >> 16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      h_q           <= '0;
      len_q         <= '0;
      nwords_q      <= '0;
      chunk_ready_q <= 1'b0;
      hash_valid_q  <= 1'b0;
      hash_out_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            h_q      <= seed_i;
            len_q    <= len_i;
            nwords_q <= len_i >> 2;
            busy_q   <= 1'b1;
            if ((len_i >> 2) != '0) begin
              state_q       <= StBody;
              chunk_ready_q <= 1'b1;
            end else if (len_i[1:0] != 2'd0) begin
              state_q       <= StTail;
              chunk_ready_q <= 1'b1;
            end else begin
              state_q <= StFin1;
            end
          end
        end
        StBody: begin
          if (chunk_valid) begin
            h_q      <= h_body;
            nwords_q <= nwords_q - LEN_W'(1);
            if (nwords_q == LEN_W'(1)) begin
              if (len_q[1:0] != 2'd0) begin
                state_q <= StTail;
              end else begin
                state_q       <= StFin1;
                chunk_ready_q <= 1'b0;
              end
            end
          end
        end
        StTail: begin
          if (chunk_valid) begin
            h_q           <= h_q ^ k_tail;
            state_q       <= StFin1;
            chunk_ready_q <= 1'b0;
          end
        end
        StFin1: begin
          h_q     <= h_fin1;
          state_q <= StFin2;
        end
        StFin2: begin
          h_q     <= h_fin2;
          state_q <= StFin3;
        end
        StFin3: begin
          h_q          <= h_fin3;
          hash_out_q   <= h_fin3;
          hash_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (hash_ready) begin
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign chunk_ready = chunk_ready_q;
  assign hash_valid  = hash_valid_q;
  assign hash_out    = hash_out_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_murmur3_stream_ctrl.sv
// Bench for murmur3_stream_ctrl: known-answer table, hand-written corner sequences and
// randomized jobs checked against a byte-level MurmurHash3 x86_32 model.
module tb_murmur3_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed_i = '0;
  logic [15:0] len_i = '0;
  logic        chunk_valid = 1'b0;
  logic [31:0] chunk_data = '0;
  logic        chunk_ready;
  logic        hash_valid;
  logic [31:0] hash_out;
  logic        hash_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  murmur3_stream_ctrl #(.LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed_i     (seed_i),
    .len_i      (len_i),
    .chunk_valid(chunk_valid),
    .chunk_data (chunk_data),
    .chunk_ready(chunk_ready),
    .hash_valid (hash_valid),
    .hash_out   (hash_out),
    .hash_ready (hash_ready),
    .busy       (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: straight from the algorithm over a byte array.
  function automatic logic [31:0] ref_hash(input logic [31:0] seed, input int len,
                                           input logic [7:0] b [64]);
    logic [31:0] h, k;
    int nb, rem;
    h  = seed;
    nb = len / 4;
    for (int i = 0; i < nb; i++) begin
      k = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
      k = k * 32'hcc9e2d51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1b873593;
      h = h ^ k;
      h = (h << 13) | (h >> 19);
      h = h * 32'd5 + 32'he6546b64;
    end
    rem = len % 4;
    k = '0;
    for (int j = 0; j < rem; j++) k = k | (32'(b[4*nb+j]) << (8 * j));
    if (rem != 0) begin
      k = k * 32'hcc9e2d51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1b873593;
      h = h ^ k;
    end
    h = h ^ 32'(len);
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  // stall < 0 selects a random 0..3 cycle gap before each chunk.
  task automatic run_job(input string name, input logic [31:0] seed, input logic [15:0] len,
                         input logic [511:0] words, input int stall, input int rdelay,
                         input bit spam, input logic [31:0] exp);
    int nw, t, s;
    nw = (int'(len) + 3) / 4;
    @(negedge clk);
    start = 1'b1; seed_i = seed; len_i = len;
    @(negedge clk);
    start = 1'b0; seed_i = $urandom; len_i = 16'($urandom);
    for (int i = 0; i < nw; i++) begin
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int j = 0; j < s; j++) begin
        chunk_valid = 1'b0; chunk_data = $urandom; start = spam;
        @(negedge clk);
      end
      chunk_valid = 1'b1; chunk_data = words[32*i +: 32]; start = spam;
      t = 0;
      while (!chunk_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check({name, " chunk_ready timeout"}, 32'(chunk_ready), 32'd1);
      @(negedge clk);
    end
    chunk_valid = 1'b0; chunk_data = $urandom;
    t = 0;
    while (!hash_valid && t < 50) begin
      start = spam; seed_i = $urandom;
      @(negedge clk);
      t++;
    end
    check({name, " hash_valid"}, 32'(hash_valid), 32'd1);
    for (int d = 0; d < rdelay; d++) begin
      start = spam;
      @(negedge clk);
      check({name, " held valid"}, 32'(hash_valid), 32'd1);
      check({name, " held hash"}, hash_out, exp);
    end
    check({name, " hash"}, hash_out, exp);
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0; start = 1'b0;
    check({name, " valid drop"}, 32'(hash_valid), 32'd0);
    check({name, " idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0]  seed;
    logic [15:0]  len;
    logic [127:0] words;
    logic [7:0]   stall;
    logic [31:0]  exp;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [7:0]   b [64];
    logic [511:0] w;
    logic [31:0]  s;
    int           len;

    vt[0] = '{seed: 32'h0,        len: 16'd0,  words: '0,            stall: 8'd0, exp: 32'h00000000};
    vt[1] = '{seed: 32'h1,        len: 16'd0,  words: '0,            stall: 8'd0, exp: 32'h514E28B7};
    vt[2] = '{seed: 32'hFFFFFFFF, len: 16'd0,  words: '0,            stall: 8'd0, exp: 32'h81F16F39};
    vt[3] = '{seed: 32'h0,        len: 16'd4,  words: 128'h74736574, stall: 8'd5, exp: 32'hBA6BD213};
    vt[4] = '{seed: 32'd1234,     len: 16'd13,
              words: {32'hAAAAAA21, 32'h646c726f, 32'h77202c6f, 32'h6c6c6548},
              stall: 8'd1, exp: 32'hFAF6CDB3};

    #1;
    check("reset chunk_ready", 32'(chunk_ready), 32'd0);
    check("reset hash_valid", 32'(hash_valid), 32'd0);
    check("reset hash_out", hash_out, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Empty message: no chunk_ready, hash_valid three edges after the start edge.
    @(negedge clk);
    start = 1'b1; seed_i = 32'h0; len_i = 16'd0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("len0 no chunk_ready", 32'(chunk_ready), 32'd0);
      if (c == 3) check("len0 not early", 32'(hash_valid), 32'd0);
      if (c < 4) @(negedge clk);
    end
    check("len0 valid at 3", 32'(hash_valid), 32'd1);
    check("len0 hash", hash_out, 32'h0);
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;

    foreach (vt[i]) begin
      run_job($sformatf("vec%0d", i), vt[i].seed, vt[i].len, 512'(vt[i].words),
              int'(vt[i].stall), 0, 1'b0, vt[i].exp);
    end

    // Consumer stalls 10 cycles while start is pulsed repeatedly.
    run_job("hold", vt[4].seed, vt[4].len, 512'(vt[4].words), 2, 10, 1'b1, vt[4].exp);

    // Async reset mid-body, then a clean job.
    @(negedge clk);
    start = 1'b1; seed_i = 32'd1234; len_i = 16'd13;
    @(negedge clk);
    start = 1'b0; chunk_valid = 1'b1; chunk_data = 32'h6c6c6548;
    @(negedge clk);
    chunk_valid = 1'b0;
    check("midbody busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst chunk_ready", 32'(chunk_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst hash_valid", 32'(hash_valid), 32'd0);
    check("rst hash_out", hash_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("after rst", 32'h0, 16'd4, 512'h74736574, 0, 0, 1'b0, 32'hBA6BD213);

    for (int r = 0; r < 25; r++) begin
      len = int'($urandom_range(0, 60));
      s = $urandom;
      for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) w[8*i +: 8] = (i < len) ? b[i] : 8'($urandom);
      run_job($sformatf("rand%0d len%0d", r, len), s, 16'(len), w, -1,
              int'($urandom_range(0, 3)), 1'($urandom), ref_hash(s, len, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
